// File: rtl/sseg_ctrl.sv
// ---------------------------------------------------------------------------
// sseg_ctrl
//   Sequential display controller for a row of sseg seven-segment decoders.
//   A signed value arrives over a valid/ready handshake and is converted to
//   BCD serially with shift-and-add-3, one bit per cycle. The result is then
//   formatted with sign placement, decimal point and overflow indication.
//   It is registered onto per-digit buses that drive sseg instances directly.
//
//   Optional feature macro: SSEG_CTRL_BLANK_EN
//     defined   : leading-zero blanking, the sign floats left of the
//                 highest kept digit
//     undefined : all digits shown, the sign is fixed at digit DIGITS-1
//
// Parameters
//   DIGITS : number of display digits (>= 2), digit 0 is rightmost
//   WIDTH  : input value width, two's complement (>= 2)
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset
//   in_valid in   value/dp_en/dp_pos present
//   in_ready out  controller idle (forced low while reset is high)
//   value    in   signed value to display
//   dp_en    in   enable decimal point
//   dp_pos   in   digit index carrying the decimal point
//   num      out  BCD nibble per digit, digit i = num[4i+3:4i]
//   blank    out  per-digit blank (1 = segments off)
//   sign     out  per-digit dash
//   dp       out  per-digit decimal point, active-high
//   ovf      out  displayed value did not fit
//   done     out  one-cycle pulse when the display outputs update
// ---------------------------------------------------------------------------
module sseg_ctrl #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            value,
  input  logic                        dp_en,
  input  logic [$clog2(DIGITS)-1:0]   dp_pos,
  output logic [4*DIGITS-1:0]         num,
  output logic [DIGITS-1:0]           blank,
  output logic [DIGITS-1:0]           sign,
  output logic [DIGITS-1:0]           dp,
  output logic                        ovf,
  output logic                        done
);

  localparam int PW = $clog2(DIGITS);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FMT  = 2'd2
  } state_t;

  state_t          state_r;
  logic [BW-1:0]   bcd_r;
  logic [WIDTH-1:0] mag_r;
  logic            neg_r;
  logic            dp_en_r;
  logic [PW-1:0]   dp_pos_r;
  logic            sticky_r;
  logic [CW-1:0]   cnt_r;

  logic [WIDTH-1:0] mag_s;
  logic [BW-1:0]    bcd_adj_s;
  logic [BW-1:0]    bcd_next_s;
  logic             dp_ok_s;
  logic [BW-1:0]    num_img_s;
  logic [DIGITS-1:0] blank_img_s;
  logic [DIGITS-1:0] sign_img_s;
  logic [DIGITS-1:0] dp_img_s;
  logic             ovf_img_s;
`ifdef SSEG_CTRL_BLANK_EN
  int               msd_s;
  int               hi_s;
`endif

  // Add 3 to every nibble that is 5 or more, so the following shift carries
  // correctly into the next decimal digit.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? (b[4*i +: 4] + 4'd3) : b[4*i +: 4];
    end
    return r;
  endfunction

  // Idle handshake; reset forces ready low combinationally.
  always_comb begin
    in_ready = (state_r == IDLE) && !reset;
  end

  // Magnitude of the incoming value; the most negative value maps to
  // 2^(WIDTH-1), which still fits the unsigned WIDTH-bit register.
  always_comb begin
    mag_s = value[WIDTH-1] ? ((~value) + WIDTH'(1)) : value;
  end

  // One shift-and-add-3 step: adjust nibbles, then shift the top magnitude
  // bit into the BCD register.
  always_comb begin
    bcd_adj_s  = add3(bcd_r);
    bcd_next_s = {bcd_adj_s[BW-2:0], mag_r[WIDTH-1]};
  end

  // Display image computed from the finished BCD value.
  always_comb begin
    // A dp_pos beyond the last digit cannot carry a point; treat it as off.
    dp_ok_s     = dp_en_r && (int'(dp_pos_r) < DIGITS);
    num_img_s   = bcd_r;
    blank_img_s = '0;
    sign_img_s  = '0;
    dp_img_s    = '0;
    ovf_img_s   = sticky_r;
    for (int i = 0; i < DIGITS; i++) begin
      dp_img_s[i] = dp_ok_s && (int'(dp_pos_r) == i);
    end
`ifdef SSEG_CTRL_BLANK_EN
    // Highest kept digit: most-significant nonzero digit, or the decimal
    // point digit if that is further left. Digit 0 is always kept.
    msd_s = 0;
    for (int i = 0; i < DIGITS; i++) begin
      msd_s = (bcd_r[4*i +: 4] != 4'd0) ? i : msd_s;
    end
    hi_s = (dp_ok_s && (int'(dp_pos_r) > msd_s)) ? int'(dp_pos_r) : msd_s;
    for (int i = 0; i < DIGITS; i++) begin
      sign_img_s[i]  = neg_r && (i == hi_s + 1);
      blank_img_s[i] = (i > hi_s) && !(neg_r && (i == hi_s + 1));
    end
    ovf_img_s = sticky_r || (neg_r && (hi_s == DIGITS - 1));
`else
    blank_img_s = '0;
    sign_img_s  = {neg_r, {(DIGITS-1){1'b0}}};
    ovf_img_s   = sticky_r ||
                  (neg_r && ((bcd_r[BW-1 -: 4] != 4'd0) ||
                             (dp_ok_s && (int'(dp_pos_r) == DIGITS - 1))));
`endif
    if (ovf_img_s) begin
      num_img_s   = '0;
      blank_img_s = '0;
      sign_img_s  = '1;
      dp_img_s    = '0;
    end else begin
      num_img_s   = bcd_r;
    end
  end

  // Controller FSM, conversion datapath and registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      bcd_r    <= '0;
      mag_r    <= '0;
      neg_r    <= 1'b0;
      dp_en_r  <= 1'b0;
      dp_pos_r <= '0;
      sticky_r <= 1'b0;
      cnt_r    <= '0;
      num      <= '0;
      blank    <= '1;
      sign     <= '0;
      dp       <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            dp_en_r  <= dp_en;
            dp_pos_r <= dp_pos;
            neg_r    <= value[WIDTH-1];
            mag_r    <= mag_s;
            bcd_r    <= '0;
            sticky_r <= 1'b0;
            cnt_r    <= CW'(WIDTH);
            state_r  <= CONV;
          end else begin
            state_r  <= IDLE;
          end
        end
        CONV: begin
          bcd_r    <= bcd_next_s;
          mag_r    <= {mag_r[WIDTH-2:0], 1'b0};
          // A carry out of the top nibble means the value needs more digits.
          sticky_r <= sticky_r | bcd_adj_s[BW-1];
          cnt_r    <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r <= FMT;
          end else begin
            state_r <= CONV;
          end
        end
        FMT: begin
          num     <= num_img_s;
          blank   <= blank_img_s;
          sign    <= sign_img_s;
          dp      <= dp_img_s;
          ovf     <= ovf_img_s;
          done    <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sseg_ctrl.sv
module tb_sseg_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] value;
  logic        dp_en;
  logic [1:0]  dp_pos;
  logic [15:0] num;
  logic [3:0]  blank;
  logic [3:0]  sign;
  logic [3:0]  dp;
  logic        ovf;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_num;
  logic [3:0]  exp_blank;
  logic [3:0]  exp_sign;
  logic [3:0]  exp_dp;
  logic        exp_ovf;

  sseg_ctrl #(.DIGITS(4), .WIDTH(12)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .value(value), .dp_en(dp_en), .dp_pos(dp_pos), .num(num),
    .blank(blank), .sign(sign), .dp(dp), .ovf(ovf), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference display image from decimal arithmetic on the signed value.
  function automatic void compute_expected(input int v, input logic de, input int dpp);
    int   mag, m, msd, hi;
    int   d[4];
    logic neg, bad;
    neg = (v < 0);
    mag = neg ? -v : v;
    m = mag;
    for (int i = 0; i < 4; i++) begin
      d[i] = m % 10;
      m = m / 10;
    end
    bad = (m != 0);
    exp_num   = 16'(d[0] + 16 * d[1] + 256 * d[2] + 4096 * d[3]);
    exp_blank = 4'b0000;
    exp_sign  = 4'b0000;
    exp_dp    = de ? 4'(1 << dpp) : 4'b0000;
`ifdef SSEG_CTRL_BLANK_EN
    msd = 0;
    for (int i = 0; i < 4; i++) if (d[i] != 0) msd = i;
    hi = msd;
    if (de && dpp > hi) hi = dpp;
    for (int i = 0; i < 4; i++) if (i > hi) exp_blank[i] = 1'b1;
    if (neg) begin
      if (hi == 3) bad = 1'b1;
      else begin
        exp_sign[hi+1]  = 1'b1;
        exp_blank[hi+1] = 1'b0;
      end
    end
`else
    msd = 0;
    hi = 0;
    if (neg) begin
      exp_sign[3] = 1'b1;
      if (d[3] != 0 || (de && dpp == 3)) bad = 1'b1;
    end
`endif
    exp_ovf = bad;
    if (bad) begin
      exp_num   = 16'h0000;
      exp_blank = 4'b0000;
      exp_sign  = 4'b1111;
      exp_dp    = 4'b0000;
    end
  endfunction

  // Transfer one value starting from a negedge; returns at the negedge of
  // the done cycle with the cycle number of done and the ready-low count.
  task automatic xfer(input int v, input logic de, input int dpp,
                      output int lat, output int low_cnt);
    int   guard;
    logic [31:0] vv;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL xfer_ready_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, guard);
    end
    vv = v;
    in_valid = 1'b1;
    value    = vv[11:0];
    dp_en    = de;
    dp_pos   = 2'(dpp);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    value    = 12'($urandom);
    dp_en    = 1'($urandom);
    dp_pos   = 2'($urandom);
    lat = 1;
    low_cnt = 0;
    while (!done && lat < 100) begin
      if (!in_ready) low_cnt++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL xfer_done_timeout: done=%0b after %0d cycles, required 1", done, lat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    value = 12'd0;
    dp_en = 1'b0;
    dp_pos = 2'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %0b, required 0", in_ready);
    end
    checks++;
    if ({num, blank, sign, dp, ovf, done} !== {16'h0000, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: num=%h blank=%b sign=%b dp=%b ovf=%b done=%b, required 0000 1111 0000 0000 0 0",
               num, blank, sign, dp, ovf, done);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %0b, required 1", in_ready);
    end
  endtask

  task automatic test_latency();
    int lat, low;
    xfer(0, 1'b0, 0, lat, low);
    compute_expected(0, 1'b0, 0);
    checks++;
    if (lat !== 14) begin
      errors++;
      $display("FAIL latency_done: done in cycle %0d, required 14", lat);
    end
    checks++;
    if (low !== 13) begin
      errors++;
      $display("FAIL latency_ready_low: low for %0d cycles, required 13", low);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL latency_ready_done: got %0b, required 1", in_ready);
    end
    checks++;
    if ({num, blank, sign, dp, ovf} !== {exp_num, exp_blank, exp_sign, exp_dp, exp_ovf}) begin
      errors++;
      $display("FAIL latency_image: got %h %b %b %b %b, required %h %b %b %b %b",
               num, blank, sign, dp, ovf, exp_num, exp_blank, exp_sign, exp_dp, exp_ovf);
    end
  endtask

  task automatic test_directed();
    int vals[6] = '{-5, -999, -1000, -2048, 2047, 5};
    int des[6]  = '{0, 0, 0, 0, 0, 1};
    int dps[6]  = '{0, 0, 0, 0, 0, 2};
    int lat, low;
    for (int i = 0; i < 6; i++) begin
      xfer(vals[i], 1'(des[i]), dps[i], lat, low);
      compute_expected(vals[i], 1'(des[i]), dps[i]);
      checks++;
      if ({num, blank, sign, dp, ovf} !== {exp_num, exp_blank, exp_sign, exp_dp, exp_ovf}) begin
        errors++;
        $display("FAIL directed_%0d: got %h %b %b %b %b, required %h %b %b %b %b", vals[i],
                 num, blank, sign, dp, ovf, exp_num, exp_blank, exp_sign, exp_dp, exp_ovf);
      end
    end
    // The most negative value never fits four digits with a sign.
    xfer(-2048, 1'b0, 0, lat, low);
    checks++;
    if (ovf !== 1'b1 || sign !== 4'b1111) begin
      errors++;
      $display("FAIL directed_min_ovf: ovf=%b sign=%b, required 1 1111", ovf, sign);
    end
  endtask

  task automatic test_random();
    int lat, low, v, dpp;
    logic de;
    for (int n = 0; n < 60; n++) begin
      v   = int'($urandom_range(0, 4095)) - 2048;
      if (n % 3 == 0) v = int'($urandom_range(0, 40)) - 20;
      de  = 1'($urandom);
      dpp = int'($urandom_range(0, 3));
      xfer(v, de, dpp, lat, low);
      compute_expected(v, de, dpp);
      checks++;
      if ({num, blank, sign, dp, ovf} !== {exp_num, exp_blank, exp_sign, exp_dp, exp_ovf}) begin
        errors++;
        $display("FAIL random v=%0d de=%0b dpp=%0d: got %h %b %b %b %b, required %h %b %b %b %b",
                 v, de, dpp, num, blank, sign, dp, ovf, exp_num, exp_blank, exp_sign, exp_dp, exp_ovf);
      end
      checks++;
      if (lat !== 14 || low !== 13) begin
        errors++;
        $display("FAIL random_timing v=%0d: done cycle %0d ready-low %0d, required 14 13", v, lat, low);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, low;
    xfer(123, 1'b0, 0, lat, low);
    // Next transfer issued in the done cycle of the previous one.
    xfer(-42, 1'b1, 1, lat, low);
    compute_expected(-42, 1'b1, 1);
    checks++;
    if (lat !== 14 || low !== 13) begin
      errors++;
      $display("FAIL b2b_timing: done cycle %0d ready-low %0d, required 14 13", lat, low);
    end
    checks++;
    if ({num, blank, sign, dp, ovf} !== {exp_num, exp_blank, exp_sign, exp_dp, exp_ovf}) begin
      errors++;
      $display("FAIL b2b_image: got %h %b %b %b %b, required %h %b %b %b %b",
               num, blank, sign, dp, ovf, exp_num, exp_blank, exp_sign, exp_dp, exp_ovf);
    end
  endtask

  task automatic test_hold();
    int lat, low;
    int pulses;
    xfer(309, 1'b1, 3, lat, low);
    compute_expected(309, 1'b1, 3);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL hold_done_pulse: %0d extra done cycles, required 0", pulses);
    end
    checks++;
    if ({num, blank, sign, dp, ovf} !== {exp_num, exp_blank, exp_sign, exp_dp, exp_ovf}) begin
      errors++;
      $display("FAIL hold_image: got %h %b %b %b %b, required %h %b %b %b %b",
               num, blank, sign, dp, ovf, exp_num, exp_blank, exp_sign, exp_dp, exp_ovf);
    end
  endtask

  task automatic test_reset_mid();
    int lat, low;
    int pulses;
    xfer(2047, 1'b0, 0, lat, low);
    in_valid = 1'b1;
    value    = 12'd123;
    dp_en    = 1'b1;
    dp_pos   = 2'd1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({num, blank, sign, dp, ovf, done, in_ready} !==
        {16'h0000, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_outputs: num=%h blank=%b sign=%b dp=%b ovf=%b done=%b rdy=%b, required reset values",
               num, blank, sign, dp, ovf, done, in_ready);
    end
    reset = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || !in_ready) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL midreset_idle: %0d cycles with done or not ready, required 0", pulses);
    end
    xfer(7, 1'b0, 0, lat, low);
    compute_expected(7, 1'b0, 0);
    checks++;
    if ({num, blank, sign, dp, ovf} !== {exp_num, exp_blank, exp_sign, exp_dp, exp_ovf} || lat !== 14) begin
      errors++;
      $display("FAIL midreset_recover: got %h %b %b %b %b lat %0d, required %h %b %b %b %b lat 14",
               num, blank, sign, dp, ovf, lat, exp_num, exp_blank, exp_sign, exp_dp, exp_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sseg_ctrl.md
# sseg_ctrl

Sequential display controller for a row of `sseg` seven-segment digit decoders. It accepts a signed binary value over a valid/ready handshake and converts it to BCD serially using shift-and-add-3, one bit per cycle. It then formats the result with leading-zero blanking, minus-sign placement, decimal-point placement and overflow indication. Registered per-digit `num`/`blank`/`sign`/`dp` buses drive `DIGITS` `sseg` instances directly.

## Interface
- `DIGITS`, default 4: number of display digits; digit 0 is rightmost (least significant).
- `WIDTH`, default 12: input value width, two's complement.
- `clk` input 1: clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: `value`/`dp_en`/`dp_pos` present.
- `in_ready` output 1: controller idle; transfer occurs on `in_valid && in_ready` at a rising edge.
- `value` input WIDTH: signed value to display.
- `dp_en` input 1: enable decimal point.
- `dp_pos` input $clog2(DIGITS): index of the digit carrying the decimal point.
- `num` output 4*DIGITS: BCD nibble per digit; digit i is `num[4i+3:4i]`. Drives `sseg.num`.
- `blank` output DIGITS: per-digit blank. Drives `sseg.en`; 1 = segments off.
- `sign` output DIGITS: per-digit dash. Drives `sseg.sign`.
- `dp` output DIGITS: per-digit decimal point, active-high. `sseg` inverts it.
- `ovf` output 1: currently displayed value did not fit.
- `done` output 1: one-cycle pulse when display outputs update.

## Operation
- **States:** IDLE, CONV, FMT.
- **IDLE**
  - `in_ready`=1.
  - On transfer: latch `dp_en`/`dp_pos`, latch `neg = value[WIDTH-1]`, latch `mag = |value|` as a WIDTH-bit unsigned value. -2^(WIDTH-1) yields magnitude 2^(WIDTH-1), which fits.
  - Clear the BCD register (4*DIGITS bits) and the sticky overflow bit; load bit counter with WIDTH; go to CONV.
- **CONV** (exactly WIDTH cycles)
  - Each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, mag} left by one.
  - Any 1 shifted out of the top of the BCD register sets sticky overflow.
  - After the counter reaches 0, go to FMT.
- **FMT** (1 cycle): compute the display image, register it into the outputs, go to IDLE.
  - **Kept digits:** digit i is kept if i ≤ the index of the most-significant nonzero BCD digit, or i ≤ `dp_pos` when `dp_en`=1. Digit 0 is always kept. All other digits get `blank`=1.
  - **Sign placement:** if `neg`, the digit immediately left of the highest kept digit gets `sign`=1, `blank`=0. If no such digit exists (highest kept = DIGITS-1), it is overflow.
  - **Decimal point:** `dp[dp_pos]` = `dp_en`; all other `dp` bits are 0.
  - **Overflow** (sticky set, or no room for the sign): every digit `sign`=1, `blank`=0, `dp`=0, `num`=0; `ovf`=1. Otherwise `ovf`=0.
- Outputs hold their value between updates. `in_valid` is ignored outside IDLE.
- **Reset values:** state IDLE, `num`=0, `blank`=all ones, `sign`=0, `dp`=0, `ovf`=0, `done`=0. `in_ready`=0 while `reset` is high.
- **Reset mid-CONV/FMT:** abandon the conversion, apply reset values, discard the in-flight value; no `done` pulse.

## Timing
- Transfer at edge k → CONV during cycles k+1…k+WIDTH → FMT during cycle k+WIDTH+1.
- Outputs are updated and `done`=1 during cycle k+WIDTH+2, with `in_ready`=1 in the same cycle.
- Throughput: one value per WIDTH+2 cycles. Back-to-back transfer is allowed in the `done` cycle.
- `in_ready` falls in cycle k+1 and stays low for WIDTH+1 cycles.
- All outputs are registered; no combinational path from inputs to outputs except `reset` → `in_ready`.

## Configuration
- **`SSEG_CTRL_BLANK_EN` defined:** leading-zero blanking and floating sign placement as described above.
- **`SSEG_CTRL_BLANK_EN` undefined:**
  - No blanking: all DIGITS digits show their BCD nibble, including leading zeros, and `blank` is always 0 after the first update.
  - If `neg`, the dash is fixed at digit DIGITS-1, and overflow occurs if BCD digit DIGITS-1 is nonzero or `dp_pos`=DIGITS-1 with `dp_en`=1.
  - Reset values are unchanged.

## Test plan
All scenarios use DIGITS=4, WIDTH=12, `SSEG_CTRL_BLANK_EN` defined unless noted.
- **Latency:** `value`=0, `dp_en`=0 → `in_ready` low 13 cycles, `done` at cycle 14; `num`=0x0000, `blank`=4'b1110, `sign`=0, `ovf`=0.
- **Negative:**
  - `value`=-5 → `num[3:0]`=5, `sign`=4'b0010, `blank`=4'b1100.
  - `value`=-999 → digits 0–2 = 9,9,9, `sign`=4'b1000, `ovf`=0.
- **Overflow:**
  - `value`=-1000 → `sign`=4'b1111, `ovf`=1.
  - `value`=-2048 → `ovf`=1.
  - `value`=2047 → `num`=0x2047, `blank`=0, `ovf`=0.
- **Decimal point:** `value`=5, `dp_en`=1, `dp_pos`=2 → `num`=0x0005, `blank`=4'b1000, `dp`=4'b0100.
- **Reset mid-CONV:** assert `reset` at CONV cycle 6 → next cycle all outputs at reset values, no `done`. After release, `in_ready`=1 and a new value of 7 converts normally.
- **Macro undefined:** `value`=-5 → `num`=0x0005, `sign`=4'b1000, `blank`=0; `value`=-1000 → `ovf`=1.
